// File: rtl/phase_timer_sched_pkg.sv
// Shared encodings for the intersection phase timer:
// decoder phase codes, light codes and scheduler states.
package phase_pkg;

  localparam logic [2:0] PH_SUD     = 3'b000;
  localparam logic [2:0] PH_EST     = 3'b001;
  localparam logic [2:0] PH_VEST    = 3'b010;
  localparam logic [2:0] PH_NORD    = 3'b011;
  localparam logic [2:0] PH_PIETONI = 3'b100;
  localparam logic [2:0] PH_SERVICE = 3'b111;

  localparam logic [1:0] LT_RED    = 2'b00;
  localparam logic [1:0] LT_GREEN  = 2'b01;
  localparam logic [1:0] LT_YELLOW = 2'b10;
  localparam logic [1:0] LT_OFF    = 2'b11;

  localparam int RDY_S = 0;
  localparam int RDY_E = 1;
  localparam int RDY_V = 2;
  localparam int RDY_N = 3;
  localparam int RDY_P = 4;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_GREEN,
    ST_YELLOW,
    ST_WALK,
    ST_DONE,
    ST_SVC
  } state_e;

endpackage

// File: rtl/phase_timer_sched_tick_counter.sv
// Loadable down-counter stepped by the divider tick.
// last is registered: it marks the tick that took the count from 1 to 0.
module tick_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;

  always_comb begin
    cnt_d  = cnt_q;
    last_d = 1'b0;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d  = cnt_q - CNT_W'(1);
      last_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign last = last_q;

endmodule

// File: rtl/phase_timer_sched.sv
// Phase timer: times green/yellow/walk intervals for the phase
// decoder, pulses ready_* per phase and drives light/walk outputs.
import phase_pkg::*;

module phase_timer_sched #(
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 4,
  parameter int PED_TICKS    = 15,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [2:0] stare_semafor,
  input  logic       button,
  input  logic       service,
  output logic       ready_S,
  output logic       ready_E,
  output logic       ready_V,
  output logic       ready_N,
  output logic       ready_P,
  output logic [1:0] light,
  output logic       ped_walk,
  output logic       ped_pending
);

  localparam int MAX_GY = (GREEN_TICKS > YELLOW_TICKS) ?
                          GREEN_TICKS : YELLOW_TICKS;
  localparam int MAX_T  = (MAX_GY > PED_TICKS) ? MAX_GY : PED_TICKS;

  if (CNT_W < 1 || MAX_T > (2 ** CNT_W) - 1) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the longest interval");
  end
  if (GREEN_TICKS < 1 || YELLOW_TICKS < 1 || PED_TICKS < 1) begin : g_bad_ticks
    $error("interval lengths must be at least one tick");
  end

  state_e           state_q, state_d;
  logic [2:0]       prev_phase_q;
  logic [4:0]       ready_q, ready_d;
  logic [1:0]       light_q, light_d;
  logic             ped_walk_q, ped_walk_d;
  logic             ped_pending_q, ped_pending_d;
  logic             ped_clr;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             last;
  logic             entry;
  logic             vehicle;

  assign entry   = (stare_semafor != prev_phase_q);
  assign vehicle = (stare_semafor[2] == 1'b0);

  tick_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (cnt_load),
    .load_val (cnt_val),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_WAIT;
      prev_phase_q  <= PH_SERVICE;
      ready_q       <= '0;
      light_q       <= LT_RED;
      ped_walk_q    <= 1'b0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_phase_q  <= stare_semafor;
      ready_q       <= ready_d;
      light_q       <= light_d;
      ped_walk_q    <= ped_walk_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  // Priority: service request, then phase entry, then tick-driven progress.
  always_comb begin
    state_d = state_q;
    if (service) begin
      state_d = ST_SVC;
    end else if (entry) begin
      if (vehicle) begin
        state_d = ST_GREEN;
      end else if (stare_semafor == PH_PIETONI) begin
        state_d = ped_pending_q ? ST_WALK : ST_DONE;
      end else if (stare_semafor == PH_SERVICE) begin
        state_d = ST_SVC;
      end else begin
        state_d = ST_WAIT;
      end
    end else begin
      unique case (state_q)
        ST_GREEN:  if (last) state_d = ST_YELLOW;
        ST_YELLOW: if (last) state_d = ST_DONE;
        ST_WALK:   if (last) state_d = ST_DONE;
        ST_SVC:    state_d = ST_WAIT;
        default:   state_d = state_q;
      endcase
    end
  end

  always_comb begin
    ready_d    = '0;
    light_d    = light_q;
    ped_walk_d = ped_walk_q;
    ped_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = CNT_W'(GREEN_TICKS);
    if (service) begin
      ped_walk_d = 1'b0;
      if (state_q != ST_SVC) begin
        light_d = LT_YELLOW;
      end else if (tick) begin
        light_d = (light_q == LT_YELLOW) ? LT_OFF : LT_YELLOW;
      end
    end else if (entry) begin
      ped_walk_d = 1'b0;
      light_d    = LT_RED;
      if (vehicle) begin
        cnt_load = 1'b1;
        light_d  = LT_GREEN;
      end else if (stare_semafor == PH_PIETONI) begin
        if (ped_pending_q) begin
          cnt_load   = 1'b1;
          cnt_val    = CNT_W'(PED_TICKS);
          ped_walk_d = 1'b1;
        end else begin
          ready_d[RDY_P] = 1'b1;
        end
      end else if (stare_semafor == PH_SERVICE) begin
        light_d = LT_YELLOW;
      end
    end else begin
      unique case (state_q)
        ST_GREEN: begin
          if (last) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(YELLOW_TICKS);
            light_d  = LT_YELLOW;
          end
        end
        ST_YELLOW: begin
          if (last) ready_d[stare_semafor[1:0]] = 1'b1;
        end
        ST_WALK: begin
          if (last) begin
            ped_walk_d     = 1'b0;
            ped_clr        = 1'b1;
            ready_d[RDY_P] = 1'b1;
          end
        end
        ST_SVC:  light_d = LT_RED;
        default: light_d = light_q;
      endcase
    end
    ped_pending_d = ped_pending_q;
    if (button && state_q != ST_WALK) ped_pending_d = 1'b1;
    if (ped_clr) ped_pending_d = 1'b0;
  end

  assign ready_S     = ready_q[RDY_S];
  assign ready_E     = ready_q[RDY_E];
  assign ready_V     = ready_q[RDY_V];
  assign ready_N     = ready_q[RDY_N];
  assign ready_P     = ready_q[RDY_P];
  assign light       = light_q;
  assign ped_walk    = ped_walk_q;
  assign ped_pending = ped_pending_q;

endmodule
